pulse_stretcher: RTL
====================

// Module: pulse_stretcher
// PURPOSE
//   Converts single-cycle request pulses into held level gates of programmable length.
//   Sits upstream of the pulse-shortening stage in the note path. Each note-on strobe
//   becomes a gate held for Duration cycles, followed by a guaranteed low gap so the
//   downstream edge detector re-arms between notes. One retrigger is queued.
// PARAMETERS
//   CNT_W       16  width of Duration and of the hold counter
//   GAP_CYCLES  2   forced-low cycles after every gate (>=1; counter sized by $clog2)
// PORTS
//   Clock     in   1      single clock, all state on posedge
//   Reset     in   1      asynchronous, active-low; clears all state immediately
//   Valid     in   1      request strobe, sampled every posedge
//   Duration  in   CNT_W  gate length in cycles, sampled only when Valid=1
//   isValid   out  1      stretched gate (registered)
//   Busy      out  1      registered; 1 whenever state != IDLE
//   Overrun   out  1      registered 1-cycle pulse: queued request overwritten
// BEHAVIOUR
//   Reset (Reset=0, async): state=IDLE, isValid=0, Busy=0, Overrun=0.
//     Also clears: counter=0, pending=0, pend_dur=0. Release is sampled synchronously.
//   Accepted request: Valid=1 and Duration!=0. Valid with Duration==0 is ignored in
//     every state: no state change, no pending change, no Overrun.
//   States: IDLE, HOLD, GAP.
//   IDLE
//     On an accepted request in cycle N: enter HOLD.
//     isValid=1 from cycle N+1 for exactly Duration cycles (latency 1).
//   HOLD
//     isValid=1; counter decrements each cycle.
//     On the last hold cycle: next state is GAP and isValid=0 next cycle.
//   GAP
//     isValid=0 for exactly GAP_CYCLES cycles.
//     At the end: if pending=1, enter HOLD with pend_dur and clear pending;
//     otherwise enter IDLE.
//   Request while HOLD or GAP
//     Latch into pend_dur and set pending=1.
//     If pending was already 1: newest Duration wins; Overrun=1 for one cycle.
//   Simultaneous events
//     Request on the last HOLD cycle: queued; the gap is still fully honoured.
//     Request on the last GAP cycle: treated as pending; HOLD starts next cycle with
//       this Duration. Overrun=1 if an older pending request existed.
//     Request in the IDLE cycle that follows GAP: normal IDLE start.
//   Guaranteed spacing: between any two gates, isValid is low >= GAP_CYCLES cycles.
//   Width: Duration max 2^CNT_W-1. Counter loads Duration-1 and counts to 0.
//     No wrap; the zero flag ends HOLD.
//   Busy: 1 on the cycle isValid first rises, through the last GAP cycle.
//     0 in IDLE. Busy=0 with pending=1 is unreachable.
//   Reset mid-operation: gate drops asynchronously; the pending request is discarded.
// STRUCTURE
//   Shared package piano_pkg: state encoding (IDLE/HOLD/GAP localparams) and the
//     GAP_CYCLES default.
//   One sub-module, hold_counter: loadable down-counter with load, en, and zero flag,
//     width parameterised. It is reused for both HOLD and GAP timing.
//   Top level: next-state logic, the pending/pend_dur register pair, and output
//     registers.
// TESTING
//   1. Reset=0 mid-gate (Duration=10, cycle 4)
//      -> isValid, Busy, Overrun=0 immediately.
//      -> After release, no gate without a new Valid.
//   2. Single Valid, Duration=5, GAP_CYCLES=2
//      -> isValid high cycles N+1..N+5; low N+6,N+7; Busy high N+1..N+7; IDLE at N+8.
//   3. Duration=0 strobe in IDLE, HOLD and GAP
//      -> No isValid change, no Busy change, no Overrun, no pending.
//   4. Valid(D=4), then Valid(D=3) during HOLD
//      -> Gate of 4, low 2, gate of 3, low 2; Overrun never asserts.
//   5. Valid(D=6), then Valid(D=2) and Valid(D=7) during HOLD
//      -> Overrun pulses once, on the D=7 cycle; second gate lasts 7 cycles.
//   6. Requests on the last HOLD cycle and on the last GAP cycle
//      -> Exactly 2 low cycles between gates.
//      -> Second gate starts the cycle after GAP ends.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the note-path gate logic: state encoding and default gap length.
package piano_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int GAP_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    GAP  = ST_GAP
  } state_t;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag; shared by the hold and gap phases.
module hold_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero; the zero flag is what ends each phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches note-on strobes into gates of programmable length, each followed by a
// forced low gap, with a single queued retrigger.
//
//   state | meaning
//   IDLE  | no gate, nothing queued
//   HOLD  | gate high, counter runs Duration-1 .. 0
//   GAP   | gate low, counter runs GAP_CYCLES-1 .. 0; queued request starts after
module pulse_stretcher
  import piano_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [CNT_W-1:0] Duration,
  output logic             isValid,
  output logic             Busy,
  output logic             Overrun
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CW    = (CNT_W > GAP_W) ? CNT_W : GAP_W;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic             pending, pending_nxt;
  logic [CNT_W-1:0] pend_dur, pend_dur_nxt;
  logic             overrun_nxt;
  logic             req;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0]    cnt_val;

  assign req = Valid && (Duration != '0);

  hold_counter #(.W(CW)) u_cnt (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    pend_dur_nxt = pend_dur;
    overrun_nxt  = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_val      = '0;

    // Any accepted request while busy goes to the queue; newest wins.
    if (req && (state != IDLE)) begin
      pending_nxt  = 1'b1;
      pend_dur_nxt = Duration;
      overrun_nxt  = pending;
    end

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = HOLD;
          cnt_load  = 1'b1;
          cnt_val   = CW'(Duration) - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = GAP;
          cnt_load  = 1'b1;
          cnt_val   = GAP_LOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (req || pending) begin
            state_nxt   = HOLD;
            pending_nxt = 1'b0;
            cnt_load    = 1'b1;
            cnt_val     = req ? (CW'(Duration) - CW'(1)) : (CW'(pend_dur) - CW'(1));
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      pend_dur <= '0;
      isValid  <= 1'b0;
      Busy     <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      pend_dur <= pend_dur_nxt;
      isValid  <= (state_nxt == HOLD);
      Busy     <= (state_nxt != IDLE);
      Overrun  <= overrun_nxt;
    end
  end

endmodule
